// File: rtl/segment7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
//   - Default scan parameters and a brightness type for the default width.
//   - scan_cfg_t groups the scan parameters so an instantiating level can keep
//     one configuration constant and pass its fields as parameter overrides.
//   - on_step() derives the per-brightness-step on-time of a digit slot.
package segment7_pkg;

    localparam int unsigned DEF_SEGMENTS     = 4;
    localparam int unsigned DEF_DIGIT_CYCLES = 1024;
    localparam int unsigned DEF_DEAD_CYCLES  = 16;
    localparam int unsigned DEF_BRIGHT_BITS  = 3;
    localparam int unsigned DEF_BLINK_FRAMES = 12;

    typedef logic [DEF_BRIGHT_BITS-1:0] bright_t;

    typedef struct packed {
        int unsigned segments;
        int unsigned digit_cycles;
        int unsigned dead_cycles;
        int unsigned bright_bits;
        int unsigned blink_frames;
    } scan_cfg_t;

    localparam scan_cfg_t DEF_SCAN_CFG = '{
        segments:     DEF_SEGMENTS,
        digit_cycles: DEF_DIGIT_CYCLES,
        dead_cycles:  DEF_DEAD_CYCLES,
        bright_bits:  DEF_BRIGHT_BITS,
        blink_frames: DEF_BLINK_FRAMES
    };

    // Cycles of light added per brightness step; 0 means the slot is too
    // short to give every brightness code at least one lit cycle.
    function automatic int unsigned on_step(input int unsigned digit_cycles,
                                            input int unsigned dead_cycles,
                                            input int unsigned bright_bits);
        if (dead_cycles >= digit_cycles) return 0;
        return (digit_cycles - dead_cycles) >> bright_bits;
    endfunction

endpackage

// File: rtl/segment7_scan_if.sv
// Digit-multiplex interface between the scan controller (master) and the
// segment decoder/mux (slave).
//   counter      : current digit index
//   enable       : global light enable
//   digit_enable : per-digit enables with blinking applied
interface segment7_scan_if
    import segment7_pkg::*;
#(
    parameter int unsigned SEGMENTS = DEF_SEGMENTS,
    parameter int unsigned C_BITS   = $clog2(SEGMENTS)
);

    logic [C_BITS-1:0]   counter;
    logic                enable;
    logic [SEGMENTS-1:0] digit_enable;

    modport master (output counter, enable, digit_enable);
    modport slave  (input  counter, enable, digit_enable);

endinterface

// File: rtl/segment7_scan.sv
// Scan/timing controller for a multiplexed 7-segment display.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   run             : 1 scans; 0 blanks and holds the scan at digit 0, phase 0
//   brightness      : lit steps per slot minus 1, sampled at slot start
//   digit_enable_in : digits to show, from the clock core
//   blink_mask      : digits that blink
//   frame_start     : one-cycle pulse when digit 0's slot begins
//   disp            : master side of the digit-multiplex interface
// Each slot starts with DEAD_CYCLES dark cycles so the digit index only
// changes while the display is dark (anti-ghosting), then lights for
// (brightness+1)*ON_STEP cycles.
module segment7_scan
    import segment7_pkg::*;
#(
    parameter int unsigned SEGMENTS     = DEF_SEGMENTS,
    parameter int unsigned C_BITS       = $clog2(SEGMENTS),
    parameter int unsigned DIGIT_CYCLES = DEF_DIGIT_CYCLES,
    parameter int unsigned DEAD_CYCLES  = DEF_DEAD_CYCLES,
    parameter int unsigned BRIGHT_BITS  = DEF_BRIGHT_BITS,
    parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic [BRIGHT_BITS-1:0] brightness,
    input  logic [SEGMENTS-1:0]    digit_enable_in,
    input  logic [SEGMENTS-1:0]    blink_mask,
    output logic                   frame_start,
    segment7_scan_if.master        disp
);

    localparam int unsigned ON_STEP = on_step(DIGIT_CYCLES, DEAD_CYCLES, BRIGHT_BITS);
    localparam int unsigned P_BITS  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned F_BITS  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [P_BITS-1:0] P_LAST = P_BITS'(DIGIT_CYCLES - 1);
    localparam logic [C_BITS-1:0] C_LAST = C_BITS'(SEGMENTS - 1);
    localparam logic [F_BITS-1:0] F_LAST = F_BITS'(BLINK_FRAMES - 1);

    if (SEGMENTS < 2 || (SEGMENTS & (SEGMENTS - 1)) != 0) begin : g_chk_segments
        $fatal(1, "segment7_scan: SEGMENTS must be a power of 2 and at least 2");
    end
    if (ON_STEP < 1) begin : g_chk_on_step
        $fatal(1, "segment7_scan: (DIGIT_CYCLES - DEAD_CYCLES) >> BRIGHT_BITS must be >= 1");
    end
    if (DEAD_CYCLES < 1) begin : g_chk_dead
        $fatal(1, "segment7_scan: DEAD_CYCLES must be at least 1");
    end
    if (BLINK_FRAMES < 1) begin : g_chk_blink
        $fatal(1, "segment7_scan: BLINK_FRAMES must be at least 1");
    end

    logic [P_BITS-1:0]      p_q, p_d;
    logic [C_BITS-1:0]      counter_q, counter_d;
    logic [F_BITS-1:0]      frame_cnt_q, frame_cnt_d;
    logic                   blink_phase_q, blink_phase_d;
    logic [BRIGHT_BITS-1:0] bright_q, bright_d;
    logic                   run_q, run_d;
    logic                   enable_q, enable_d;
    logic                   frame_start_q, frame_start_d;
    logic [SEGMENTS-1:0]    digit_enable_q, digit_enable_d;

    logic [BRIGHT_BITS-1:0] bright_eff;
    logic [31:0]            on_len;
    logic                   slot_wrap;
    logic                   frame_wrap;

    always_comb begin
        // The brightness input is taken while p=0; bypassing it here lets the
        // first lit cycle of the slot already use the newly sampled value.
        bright_eff = (p_q == '0) ? brightness : bright_q;
        bright_d   = bright_eff;
        on_len     = (32'(bright_eff) + 32'd1) * ON_STEP;

        slot_wrap  = run_q && (p_q == P_LAST);
        frame_wrap = slot_wrap && (counter_q == C_LAST);

        run_d         = run;
        p_d           = '0;
        counter_d     = '0;
        frame_cnt_d   = '0;
        blink_phase_d = 1'b0;

        if (run && run_q) begin
            p_d           = slot_wrap ? '0 : p_q + P_BITS'(1);
            counter_d     = slot_wrap ? counter_q + C_BITS'(1) : counter_q;
            frame_cnt_d   = frame_cnt_q;
            blink_phase_d = blink_phase_q;
            if (frame_wrap) begin
                if (frame_cnt_q == F_LAST) begin
                    frame_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + F_BITS'(1);
                end
            end
        end

        // Outputs are computed from next-state values so each registered
        // output lines up with the registered slot phase it belongs to.
        enable_d = run && (32'(p_d) >= DEAD_CYCLES) && (32'(p_d) < DEAD_CYCLES + on_len);

        // With run=1, p_d=0 and counter_d=0 only occur at a frame wrap or on
        // the first edge after scanning resumes.
        frame_start_d = run && (p_d == '0) && (counter_d == '0);

        digit_enable_d = digit_enable_in & ~(blink_mask & {SEGMENTS{blink_phase_d}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q            <= '0;
            counter_q      <= '0;
            frame_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            bright_q       <= '0;
            run_q          <= 1'b0;
            enable_q       <= 1'b0;
            frame_start_q  <= 1'b0;
            digit_enable_q <= '0;
        end else begin
            p_q            <= p_d;
            counter_q      <= counter_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_phase_q  <= blink_phase_d;
            bright_q       <= bright_d;
            run_q          <= run_d;
            enable_q       <= enable_d;
            frame_start_q  <= frame_start_d;
            digit_enable_q <= digit_enable_d;
        end
    end

    assign disp.counter      = counter_q;
    assign disp.enable       = enable_q;
    assign disp.digit_enable = digit_enable_q;
    assign frame_start       = frame_start_q;

endmodule
